// File: rtl/spi_norm.sv
// Byte-wide SPI master, mode 0, single chip select; MSB first by default.
// Define SPI_NORM_LSB_FIRST_EN to send and capture LSB first instead.
module spi_norm #(
   parameter int DIV_FREQ_BY = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] data,
   input  logic       load_data,
   input  logic       miso,
   output logic       mosi,
   output logic       cs,
   output logic       sck,
   output logic       busy,
   output logic [7:0] received_data
);

   localparam int H  = DIV_FREQ_BY / 2;
   localparam int CW = $clog2(H) + 1;
   localparam logic [CW-1:0] H_LAST = CW'(H - 1);

   generate
      if ((DIV_FREQ_BY < 2) || ((DIV_FREQ_BY % 2) != 0)) begin : g_bad_div
         $error("spi_norm: DIV_FREQ_BY must be even and >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    tx;
   logic [7:0]    rx;
   logic [7:0]    tx_shifted;
   logic [7:0]    rx_shifted;

   // mosi is a tap of the tx register; zero fill leaves it low once all 8 bits are out
`ifdef SPI_NORM_LSB_FIRST_EN
   assign mosi       = tx[0];
   assign tx_shifted = {1'b0, tx[7:1]};
   assign rx_shifted = {miso, rx[7:1]};
`else
   assign mosi       = tx[7];
   assign tx_shifted = {tx[6:0], 1'b0};
   assign rx_shifted = {rx[6:0], miso};
`endif

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_cnt       <= '0;
         tx            <= '0;
         rx            <= '0;
         cs            <= 1'b1;
         sck           <= 1'b0;
         busy          <= 1'b0;
         received_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load_data) begin
                  tx      <= data;
                  rx      <= '0;
                  cnt     <= '0;
                  bit_cnt <= '0;
                  cs      <= 1'b0;
                  sck     <= 1'b0;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt == H_LAST) begin
                  cnt <= '0;
                  sck <= ~sck;
                  if (!sck) begin
                     rx <= rx_shifted;
                  end else begin
                     // falling edge: advance to the next bit, or leave after the 8th
                     tx      <= tx_shifted;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        tx    <= '0;
                        state <= TAIL;
                     end
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            TAIL: begin
               if (cnt == H_LAST) begin
                  cnt           <= '0;
                  cs            <= 1'b1;
                  busy          <= 1'b0;
                  received_data <= rx;
                  state         <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               cs    <= 1'b1;
               sck   <= 1'b0;
               busy  <= 1'b0;
               tx    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_norm.sv
// Scoreboard bench for spi_norm: expected mosi bits and received bytes are queued
// at load time and checked by a negedge monitor as the transfer unfolds.
module tb_spi_norm;

   localparam int DIV = 4;
   localparam int H   = DIV / 2;
`ifdef SPI_NORM_LSB_FIRST_EN
   localparam bit LSB = 1'b1;
`else
   localparam bit LSB = 1'b0;
`endif

   logic       CLK;
   logic       RESET;
   logic [7:0] data;
   logic       load_data;
   logic       miso;
   logic       mosi;
   logic       cs;
   logic       sck;
   logic       busy;
   logic [7:0] received_data;

   logic       loop_en;
   logic       slave_bit;
   logic [7:0] miso_pat;

   int n_run;
   int n_fail;

   logic       bitq[$];
   logic [7:0] rxq[$];

   assign miso = loop_en ? mosi : slave_bit;

   spi_norm #(.DIV_FREQ_BY(DIV)) dut (
      .CLK(CLK), .RESET(RESET), .data(data), .load_data(load_data), .miso(miso),
      .mosi(mosi), .cs(cs), .sck(sck), .busy(busy), .received_data(received_data)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push_bits(input logic [7:0] d);
      for (int i = 0; i < 8; i++) bitq.push_back(LSB ? d[i] : d[7-i]);
   endtask

   // load one byte; caller guarantees busy is low
   task automatic send(input logic [7:0] d, input logic [7:0] rx_exp);
      push_bits(d);
      rxq.push_back(rx_exp);
      data      = d;
      load_data = 1'b1;
      @(posedge CLK); #1;
      load_data = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_cs", cs, 0);
      chk("start_sck", sck, 0);
      chk("first_bit", mosi, LSB ? d[0] : d[7]);
   endtask

   task automatic wait_done();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(posedge CLK); #1;
         if (!busy && rxq.size() == 0 && bitq.size() == 0) done = 1'b1;
      end
      if (!done) chk("timeout", 0, 1);
   endtask

   // monitor: checks each bit at sck rise and each byte at busy fall
   initial begin
      logic sck_q, busy_q, eb;
      logic [7:0] er;
      int busy_len, rises, slave_idx;
      sck_q = 0; busy_q = 0; busy_len = 0; rises = 0; slave_idx = 0;
      slave_bit = 1'b0;
      forever begin
         @(negedge CLK);
         if (!RESET) begin
            bitq.delete();
            rxq.delete();
            sck_q = 0; busy_q = 0; slave_idx = 0;
         end else begin
            if (busy && !busy_q) begin
               busy_len = 0; rises = 0; slave_idx = 0;
            end
            if (busy) busy_len++;
            if (sck && !sck_q) begin
               rises++;
               chk("cs_active", cs, 0);
               if (bitq.size() == 0) chk("mosi_extra", 1, 0);
               else begin
                  eb = bitq.pop_front();
                  chk("mosi_bit", mosi, eb);
               end
            end
            if (!sck && sck_q && slave_idx < 8) slave_idx++;
            if (!busy && busy_q) begin
               chk("busy_len", busy_len, 17 * H);
               chk("sck_rises", rises, 8);
               chk("cs_end", cs, 1);
               chk("mosi_end", mosi, 0);
               if (rxq.size() == 0) chk("rx_extra", 1, 0);
               else begin
                  er = rxq.pop_front();
                  chk("rx_data", received_data, er);
               end
            end
            sck_q  = sck;
            busy_q = busy;
         end
         slave_bit = (slave_idx < 8) ? miso_pat[LSB ? slave_idx : 7 - slave_idx] : 1'b0;
      end
   end

   initial begin
      bit seen_low;
      n_run = 0; n_fail = 0;
      RESET = 1'b0; load_data = 1'b0; data = 8'h00; loop_en = 1'b1; miso_pat = 8'h00;

      // reset state
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_cs", cs, 1);
      chk("rst_sck", sck, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rx", received_data, 8'h00);
      RESET = 1'b1;
      @(posedge CLK); #1;

      // single loopback transfer
      send(8'hA5, 8'hA5);
      wait_done();

      // load held high: back-to-back transfers, new byte presented while busy is low
      push_bits(8'h3C); rxq.push_back(8'h3C);
      push_bits(8'hC3); rxq.push_back(8'hC3);
      data = 8'h3C; load_data = 1'b1;
      @(posedge CLK); #1;
      chk("b2b_first", busy, 1);
      seen_low = 1'b0;
      for (int i = 0; i < 100 && !seen_low; i++) begin
         @(posedge CLK); #1;
         if (!busy) seen_low = 1'b1;
      end
      if (!seen_low) chk("b2b_timeout", 0, 1);
      data = 8'hC3;
      @(posedge CLK); #1;
      chk("b2b_restart", busy, 1);
      chk("b2b_first_bit", mosi, LSB ? 1'b1 : 1'b1);
      load_data = 1'b0;
      wait_done();

      // load pulse mid-transfer must be ignored
      send(8'h96, 8'h96);
      repeat (7) @(posedge CLK);
      #1;
      data = 8'hFF; load_data = 1'b1;
      @(posedge CLK); #1;
      load_data = 1'b0; data = 8'h00;
      wait_done();
      repeat (3) @(posedge CLK);
      #1;
      chk("no_restart", busy, 0);

      // reset mid-transfer aborts immediately
      send(8'h5A, 8'h5A);
      repeat (13) @(posedge CLK);
      #1;
      chk("abort_pre_busy", busy, 1);
      RESET = 1'b0;
      @(posedge CLK); #1;
      chk("abort_cs", cs, 1);
      chk("abort_busy", busy, 0);
      chk("abort_sck", sck, 0);
      chk("abort_mosi", mosi, 0);
      chk("abort_rx", received_data, 8'h00);
      @(posedge CLK); #1;
      RESET = 1'b1;
      @(posedge CLK); #1;
      chk("abort_idle", busy, 0);

      // recovery after abort
      send(8'h69, 8'h69);
      wait_done();

      // independent slave pattern: bit ordering of capture
      loop_en = 1'b0;
      miso_pat = 8'h80;
      send(8'h01, 8'h80);
      wait_done();
      miso_pat = 8'h3B;
      send(8'hE4, 8'h3B);
      wait_done();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
